fetch_unit: RTL and testbench

Instruction fetch front end for the five-stage pipeline: owns the fetch PC, issues requests to a variable-latency instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry prefetch queue. It feeds the IF/ID pipeline register with instruction + PC+4 under a valid/ready handshake. It accepts branch/jump redirects resolved in ID, discarding wrong-path instructions.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          DEPTH_DEFAULT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small prefetch queue holding {instr, pc_4}; flush wins over push/pop
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_push   = push && !flush;
  assign do_pop    = pop && !flush;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Entry storage is left as-is on flush; count alone decides validity.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, imem req/ack sequencing, redirect handling, prefetch queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_4,
  input  logic        out_ready
);

  localparam int             CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   issue_addr_q, issue_addr_d;
  logic [31:0]   target, pc_plus4;
  logic [CW-1:0] count, post_count;
  logic          push, pop;
  fetch_entry_t  push_entry, head;

  assign target     = word_align(redirect_pc);
  assign pc_plus4   = fetch_pc_q + 32'd4;
  assign push_entry = '{instr: imem_rdata, pc_4: pc_plus4};

  assign out_valid  = (count != '0);
  assign out_instr  = head.instr;
  assign out_pc_4   = head.pc_4;
  assign pop        = out_valid && out_ready && !redirect;
  assign post_count = count + {{(CW-1){1'b0}}, 1'b1} - {{(CW-1){1'b0}}, pop};

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    issue_addr_d = issue_addr_q;
    push         = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = ST_FETCH;
        end else if (count < FULL) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          fetch_pc_d = target;
          // An outstanding request cannot be withdrawn, so park it and wait out its ack.
          if (!imem_ack) begin
            issue_addr_d = fetch_pc_q;
            state_d      = ST_DISCARD;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_plus4;
          if (post_count == FULL) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = issue_addr_q;
        if (redirect) begin
          fetch_pc_d = target;
        end
        if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      issue_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      issue_addr_q <= issue_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (64)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency memory model
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;
  logic        imem_req, imem_ack, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc_4;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          pops = 0;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc4;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc_4    (out_pc_4),
    .out_ready   (out_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0]};
  endfunction

  assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata = imem_ack ? instr_of(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  // Samples just before each rising edge, after the tasks have settled the inputs.
  always @(negedge clock) begin
    #2;
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_cmp++;
        if (!imem_req || imem_addr !== hold_addr) begin
          n_fail++;
          $display("FAIL req_hold: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, hold_addr);
        end
      end
      hold_pend = imem_req && !imem_ack;
      hold_addr = imem_addr;
      if (out_valid && out_ready && !redirect) begin
        pops++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pop: pc_4=%h, required no output", out_pc_4);
        end else begin
          exp_pc4 = sb_q.pop_front();
          if (out_pc_4 !== exp_pc4 || out_instr !== instr_of(exp_pc4 - 32'd4)) begin
            n_fail++;
            $display("FAIL pop_data: pc_4=%h instr=%h, required pc_4=%h instr=%h",
                     out_pc_4, out_instr, exp_pc4, instr_of(exp_pc4 - 32'd4));
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    redirect  = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    sb_q.delete();
    pops  = 0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h3000 || out_valid !== 1'b0 ||
        out_instr !== 32'h0 || out_pc_4 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: req=%0b addr=%h valid=%0b instr=%h pc_4=%h, required 0/3000/0/0/0",
               imem_req, imem_addr, out_valid, out_instr, out_pc_4);
    end
    mem_lat = 0;
    reset_dut();
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle0_req: req=%0b, required 0", imem_req);
    end
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL reset_cycle1_req: req=%0b addr=%h, required 1/3000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    mem_lat = 0;
    reset_dut();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) sb_q.push_back(32'h3004 + 32'(4 * k));
    tick();
    n_cmp++;
    if (imem_addr !== 32'h3000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_c1: addr=%h valid=%0b, required 3000/0", imem_addr, out_valid);
    end
    for (int c = 2; c <= 8; c++) begin
      tick();
      n_cmp++;
      if (imem_addr !== 32'h3000 + 32'(4 * (c - 1)) || !out_valid ||
          out_pc_4 !== 32'h3000 + 32'(4 * (c - 1))) begin
        n_fail++;
        $display("FAIL stream_c%0d: addr=%h valid=%0b pc_4=%h, required addr=pc_4=%h valid=1",
                 c, imem_addr, out_valid, out_pc_4, 32'h3000 + 32'(4 * (c - 1)));
      end
    end
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (pops != 7 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_pops: pops=%0d left=%0d, required 7/0", pops, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 0;
    reset_dut();
    repeat (3) tick();
    for (int c = 3; c <= 4; c++) begin
      n_cmp++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h3008 || !out_valid || out_pc_4 !== 32'h3004) begin
        n_fail++;
        $display("FAIL bp_full_c%0d: req=%0b addr=%h valid=%0b pc_4=%h, required 0/3008/1/3004",
                 c, imem_req, imem_addr, out_valid, out_pc_4);
      end
      if (c == 3) tick();
    end
    sb_q.push_back(32'h3004);
    sb_q.push_back(32'h3008);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
      n_fail++;
      $display("FAIL bp_refetch: valid=%0b req=%0b addr=%h, required 0/1/3008", out_valid, imem_req, imem_addr);
    end
    n_cmp++;
    if (pops != 2 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_pops: pops=%0d left=%0d, required 2/0", pops, sb_q.size());
    end
  endtask

  task automatic test_redirect_latency();
    mem_lat = 3;
    reset_dut();
    out_ready = 1'b1;
    sb_q.push_back(32'h3004);
    sb_q.push_back(32'h4004);
    repeat (5) tick();
    n_cmp++;
    if (imem_addr !== 32'h3004 || imem_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_c5: addr=%h ack=%0b, required 3004/0", imem_addr, imem_ack);
    end
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h4002;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_discard: req=%0b addr=%h valid=%0b, required 1/3004/0", imem_req, imem_addr, out_valid);
    end
    tick();
    n_cmp++;
    if (imem_addr !== 32'h3004 || imem_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_discard_ack: addr=%h ack=%0b, required 3004/1", imem_addr, imem_ack);
    end
    tick();
    n_cmp++;
    if (imem_addr !== 32'h4000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_target: addr=%h valid=%0b, required 4000/0", imem_addr, out_valid);
    end
    repeat (4) tick();
    n_cmp++;
    if (!out_valid || out_pc_4 !== 32'h4004) begin
      n_fail++;
      $display("FAIL lat_first_out: valid=%0b pc_4=%h, required 1/4004", out_valid, out_pc_4);
    end
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (pops != 2 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL lat_pops: pops=%0d left=%0d, required 2/0", pops, sb_q.size());
    end
  endtask

  task automatic test_redirect_ack();
    mem_lat = 0;
    reset_dut();
    out_ready = 1'b1;
    sb_q.push_back(32'h3004);
    sb_q.push_back(32'h5004);
    repeat (3) tick();
    n_cmp++;
    if (imem_addr !== 32'h3008 || imem_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rack_c3: addr=%h ack=%0b, required 3008/1", imem_addr, imem_ack);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h5000;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (imem_addr !== 32'h5000 || imem_req !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rack_target: addr=%h req=%0b valid=%0b, required 5000/1/0", imem_addr, imem_req, out_valid);
    end
    repeat (2) tick();
    out_ready = 1'b0;
    n_cmp++;
    if (pops != 2 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rack_pops: pops=%0d left=%0d, required 2/0", pops, sb_q.size());
    end
  endtask

  task automatic test_full_redirect();
    mem_lat = 0;
    reset_dut();
    repeat (3) tick();
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h6000;
    tick();
    redirect  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h6000) begin
      n_fail++;
      $display("FAIL full_redirect: valid=%0b req=%0b addr=%h, required 0/1/6000", out_valid, imem_req, imem_addr);
    end
    n_cmp++;
    if (pops != 0) begin
      n_fail++;
      $display("FAIL full_redirect_pops: pops=%0d, required 0", pops);
    end
  endtask

  task automatic test_reset_discard();
    mem_lat = 3;
    reset_dut();
    repeat (5) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h7000;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin
      n_fail++;
      $display("FAIL rd_in_discard: req=%0b addr=%h, required 1/3004", imem_req, imem_addr);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h3000 || out_valid !== 1'b0 ||
        out_instr !== 32'h0 || out_pc_4 !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_async_reset: req=%0b addr=%h valid=%0b instr=%h pc_4=%h, required 0/3000/0/0/0",
               imem_req, imem_addr, out_valid, out_instr, out_pc_4);
    end
    reset_dut();
    out_ready = 1'b1;
    sb_q.push_back(32'h3004);
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL rd_restart: req=%0b addr=%h, required 1/3000", imem_req, imem_addr);
    end
    repeat (4) tick();
    n_cmp++;
    if (!out_valid || out_pc_4 !== 32'h3004) begin
      n_fail++;
      $display("FAIL rd_restart_out: valid=%0b pc_4=%h, required 1/3004", out_valid, out_pc_4);
    end
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (pops != 1 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_pops: pops=%0d left=%0d, required 1/0", pops, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_ack();
    test_full_redirect();
    test_reset_discard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
